// File: rtl/pwl_sample_fifo.sv
// Samples a piecewise-linear signal on each enabled clock edge into a small FIFO
// and drives a hysteretic slicer with a transition counter and sticky overflow.
`timescale 1ns/1ps

package pwl_pkg;
  // pwl fields carried as IEEE-754 bit patterns: value = a + b*(t - t0), t in seconds
  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t0;
  } pwl_t;
endpackage

module pwl_sample_fifo
  import pwl_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter real VTH   = 0.0,
  parameter real VHYS  = 0.0
) (
  input  logic        clk,
  input  logic        rstn,
  input  pwl_t        in,
  input  logic        enable,
  output real         out_val,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic        dout,
  output logic [15:0] ncross,
  output logic        ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  real         mem_q [DEPTH];
  real         last_q, last_d;
  logic        dout_q;
  logic [15:0] ncross_q;
  logic        ovf_q, ovf_d;
  logic        full, pop, push;

  // Module time unit is 1 ns; pwl slope/origin are in seconds.
  function automatic real pwl_eval(input pwl_t p);
    real t;
    t = $realtime * 1.0e-9;
    return $bitstoreal(p.a) + $bitstoreal(p.b) * (t - $bitstoreal(p.t0));
  endfunction

  function automatic logic slice(input real s, input logic cur);
    if (s > VTH + VHYS / 2.0) return 1'b1;
    if (s < VTH - VHYS / 2.0) return 1'b0;
    return cur;
  endfunction

  always_comb begin
    out_vld = (wptr_q != rptr_q);
    full    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
    pop     = out_vld & out_rdy;
    // a pop on the same edge frees the slot the write needs
    push    = enable & (~full | pop);
    wptr_d  = push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    last_d  = pop  ? mem_q[rptr_q[AW-1:0]] : last_q;
    ovf_d   = ovf_q | (enable & full & ~pop);
    out_val = out_vld ? mem_q[rptr_q[AW-1:0]] : last_q;
  end

  always_ff @(posedge clk) begin
    if (push && rstn) mem_q[wptr_q[AW-1:0]] <= pwl_eval(in);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      last_q   <= 0.0;
      dout_q   <= 1'b0;
      ncross_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
      if (enable) begin
        dout_q <= slice(pwl_eval(in), dout_q);
        if (slice(pwl_eval(in), dout_q) != dout_q) ncross_q <= ncross_q + 16'd1;
      end
    end
  end

  assign dout   = dout_q;
  assign ncross = ncross_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_pwl_sample_fifo.sv
// Directed bench for pwl_sample_fifo: ramp sampling, overflow, slicer, enable gating,
// full read/write with async reset, and a queue-model run across pointer wrap.
`timescale 1ns/1ps

module tb_pwl_sample_fifo;
  import pwl_pkg::*;

  logic        clk, rstn, enable, out_rdy, dout, out_vld, ovf;
  pwl_t        pin;
  real         out_val;
  logic [15:0] ncross;
  int          n_tests = 0, n_fail = 0;

  pwl_sample_fifo #(.DEPTH(4), .VTH(0.5), .VHYS(0.2)) dut (
    .clk(clk), .rstn(rstn), .in(pin), .enable(enable), .out_val(out_val),
    .out_vld(out_vld), .out_rdy(out_rdy), .dout(dout), .ncross(ncross), .ovf(ovf)
  );

  // rising edges land on whole nanoseconds
  initial begin
    clk = 1'b1;
    forever #0.5 clk = ~clk;
  end

  task automatic set_in(input real a, input real b, input real t0);
    pin.a  = $realtobits(a);
    pin.b  = $realtobits(b);
    pin.t0 = $realtobits(t0);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    out_rdy = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; out_rdy = 1'b0;
    set_in(5.0, 0.0, 0.0);
    repeat (3) @(negedge clk);
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", out_vld); end
    n_tests++; if (out_val != 0.0) begin n_fail++; $display("FAIL reset_val: got %f want 0.0", out_val); end
    n_tests++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b want 0", dout); end
    n_tests++; if (ncross !== 16'd0) begin n_fail++; $display("FAIL reset_ncross: got %0d want 0", ncross); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rstn = 1'b1;
  endtask

  task automatic test_ramp();
    // next edge is 0.5 ns away; place t0 one period before it
    set_in(0.0, 1.0e9, ($realtime + 0.5 - 1.0) * 1.0e-9);
    enable = 1'b1; out_rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_tests++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL ramp_vld[%0d]: got %b want 1", k, out_vld); end
      n_tests++;
      if (out_val > k + 1.0e-6 || out_val < k - 1.0e-6) begin
        n_fail++; $display("FAIL ramp_val[%0d]: got %f want %f", k, out_val, real'(k));
      end
    end
    enable = 1'b0;
    @(negedge clk);
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL ramp_empty_vld: got %b want 0", out_vld); end
    n_tests++;
    if (out_val > 3.000001 || out_val < 2.999999) begin
      n_fail++; $display("FAIL ramp_hold_val: got %f want 3.0", out_val);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1; out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(10.0 + k, 0.0, 0.0);
      @(negedge clk);
      if (k == 3) begin
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at4: got %b want 0", ovf); end
      end
    end
    n_tests++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL ovf_vld: got %b want 1", out_vld); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_at5: got %b want 1", ovf); end
    n_tests++; if (out_val != 10.0) begin n_fail++; $display("FAIL ovf_head: got %f want 10.0", out_val); end
    enable = 1'b0; out_rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_val != 10.0 + k) begin n_fail++; $display("FAIL drain[%0d]: got %f want %f", k, out_val, 10.0 + k); end
    end
    @(negedge clk);
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", out_vld); end
    n_tests++; if (out_val != 13.0) begin n_fail++; $display("FAIL drain_hold: got %f want 13.0", out_val); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_slicer();
    real         vals [5] = '{0.0, 0.55, 0.65, 0.45, 0.35};
    logic        exp_d [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] exp_n [5] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2};
    do_reset();
    enable = 1'b1; out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_in(vals[k], 0.0, 0.0);
      @(negedge clk);
      n_tests++; if (dout !== exp_d[k]) begin n_fail++; $display("FAIL slicer_dout[%0d]: got %b want %b", k, dout, exp_d[k]); end
      n_tests++; if (ncross !== exp_n[k]) begin n_fail++; $display("FAIL slicer_ncross[%0d]: got %0d want %0d", k, ncross, exp_n[k]); end
    end
  endtask

  task automatic test_enable();
    // FIFO holds the last slicer sample (0.35); a high input must not reach the slicer
    enable = 1'b0;
    set_in(0.9, 0.0, 0.0);
    @(negedge clk);
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL en_pop_vld: got %b want 0", out_vld); end
    n_tests++; if (out_val != 0.35) begin n_fail++; $display("FAIL en_pop_val: got %f want 0.35", out_val); end
    repeat (2) @(negedge clk);
    n_tests++; if (dout !== 1'b0) begin n_fail++; $display("FAIL en_dout: got %b want 0", dout); end
    n_tests++; if (ncross !== 16'd2) begin n_fail++; $display("FAIL en_ncross: got %0d want 2", ncross); end
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL en_nowrite: got %b want 0", out_vld); end
    enable = 1'b1;
    @(negedge clk);
    n_tests++; if (dout !== 1'b1) begin n_fail++; $display("FAIL en_resume_dout: got %b want 1", dout); end
    n_tests++; if (ncross !== 16'd3) begin n_fail++; $display("FAIL en_resume_ncross: got %0d want 3", ncross); end
  endtask

  task automatic test_full_rw();
    do_reset();
    enable = 1'b1; out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(20.0 + k, 0.0, 0.0);
      @(negedge clk);
    end
    n_tests++; if (out_val != 20.0) begin n_fail++; $display("FAIL full_head: got %f want 20.0", out_val); end
    out_rdy = 1'b1;
    set_in(24.0, 0.0, 0.0);
    @(negedge clk);
    n_tests++; if (out_val != 21.0) begin n_fail++; $display("FAIL full_rw_head: got %f want 21.0", out_val); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_rw_ovf: got %b want 0", ovf); end
    out_rdy = 1'b0;
    set_in(25.0, 0.0, 0.0);
    @(negedge clk);
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL full_drop_ovf: got %b want 1", ovf); end
    n_tests++; if (out_val != 21.0) begin n_fail++; $display("FAIL full_drop_head: got %f want 21.0", out_val); end
    #0.2 rstn = 1'b0;
    #0.1;
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld: got %b want 0", out_vld); end
    n_tests++; if (out_val != 0.0) begin n_fail++; $display("FAIL arst_val: got %f want 0.0", out_val); end
    n_tests++; if (dout !== 1'b0) begin n_fail++; $display("FAIL arst_dout: got %b want 0", dout); end
    n_tests++; if (ncross !== 16'd0) begin n_fail++; $display("FAIL arst_ncross: got %0d want 0", ncross); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL arst_ovf: got %b want 0", ovf); end
    enable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL arst_stale: got %b want 0", out_vld); end
    enable = 1'b1; out_rdy = 1'b1;
    set_in(30.0, 0.0, 0.0);
    @(negedge clk);
    n_tests++; if (out_val != 30.0) begin n_fail++; $display("FAIL arst_first: got %f want 30.0", out_val); end
  endtask

  task automatic test_random();
    real  q [$];
    logic ovf_m = 1'b0;
    logic rdy, pop_m, full_m;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rdy = 1'($urandom_range(0, 1));
      out_rdy = rdy; enable = 1'b1;
      set_in(100.0 + i, 0.0, 0.0);
      pop_m  = (q.size() > 0) && rdy;
      full_m = (q.size() == 4);
      if (pop_m) void'(q.pop_front());
      if (!full_m || pop_m) q.push_back(100.0 + i);
      else ovf_m = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_vld !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_vld[%0d]: got %b want %b", i, out_vld, q.size() > 0); end
      if (q.size() > 0) begin
        n_tests++; if (out_val != q[0]) begin n_fail++; $display("FAIL rnd_head[%0d]: got %f want %f", i, out_val, q[0]); end
      end
      n_tests++; if (ovf !== ovf_m) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, ovf, ovf_m); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_overflow();
    test_slicer();
    test_enable();
    test_full_rw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
